// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   state_e      : controller states
//   MUL_*        : mul_signed codes ([1]=multiplicand signed, [0]=multiplier signed)
//   W32_STEPS    : Booth digit count for a 32-bit (mulw) operation
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_US = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_SS = 2'b11;

  localparam int unsigned W32_STEPS = 17;

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector (combinational).
//   triplet : {b[2i+1], b[2i], b[2i-1]}
//   a       : multiplicand, already extended to XLEN+2 bits
//   pp_c    : selected partial product, XLEN+3 bits (room for +/-2A)
//   neg_c   : carry-in completing the two's-complement negation of pp_c
module booth_r4_sel #(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      triplet,
  input  logic [XLEN+1:0] a,
  output logic [XLEN+2:0] pp_c,
  output logic            neg_c
);

  localparam int unsigned PW = XLEN + 3;

  logic [PW-1:0] a1;
  logic [PW-1:0] a2;

  // Negative digits are returned as ~(k*A); the +1 is folded into the accumulator add.
  always_comb begin
    a1    = PW'($signed(a));
    a2    = {a, 1'b0};
    pp_c  = '0;
    neg_c = 1'b0;
    unique case (triplet)
      3'b001, 3'b010: pp_c = a1;
      3'b011:         pp_c = a2;
      3'b100: begin
        pp_c  = ~a2;
        neg_c = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_c  = ~a1;
        neg_c = 1'b1;
      end
      default:        pp_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier, one Booth digit per cycle.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   mul_valid / mul_ready : request handshake (not accepted while flush is high)
//   flush                 : abort any in-flight operation, return to IDLE
//   mulw                  : 32-bit op on operand bits [31:0], 17 steps
//   mul_signed            : [1]=multiplicand signed, [0]=multiplier signed
//   multiplicand/multiplier : operands, sampled only on accept
//   out_valid             : one-cycle completion pulse
//   result_hi/result_lo   : product halves, held until the next completion
module booth_seq_mul
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            mul_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int unsigned AW    = XLEN + 2;
  localparam int unsigned PW    = XLEN + 3;
  localparam int unsigned ACCW  = 2 * AW;
  localparam int unsigned STEPS = AW / 2;
  localparam int unsigned CNTW  = $clog2(STEPS);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;
  logic [AW-1:0]     a_q, a_d;
  logic [AW-1:0]     b_q, b_d;
  logic              prev_q, prev_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              mulw_q, mulw_d;

  logic              accept;
  logic              a_sgn, b_sgn;
  logic              last_step;
  logic [PW-1:0]     pp_c;
  logic              neg_c;
  logic [ACCW-1:0]   pp_ext;
  logic [ACCW-1:0]   step_sum;
  logic [CNTW:0]     shamt;
  logic              unused_acc_top;

  // Operand extension: full width or low word, sign/zero by flag, to XLEN+2 bits.
  function automatic logic [AW-1:0] ext_op(input logic [XLEN-1:0] x,
                                           input logic            sgn,
                                           input logic            w32);
    logic [AW-1:0] r;
    if (w32) begin
      if (sgn) r = AW'($signed(x[31:0]));
      else     r = AW'(x[31:0]);
    end else begin
      if (sgn) r = AW'($signed(x));
      else     r = AW'(x);
    end
    return r;
  endfunction

  booth_r4_sel #(.XLEN(XLEN)) u_sel (
    .triplet ({b_q[1], b_q[0], prev_q}),
    .a       (a_q),
    .pp_c    (pp_c),
    .neg_c   (neg_c)
  );

  // Signedness decode of the request code.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (mul_signed)
      MUL_UU: begin a_sgn = 1'b0; b_sgn = 1'b0; end
      MUL_US: begin a_sgn = 1'b0; b_sgn = 1'b1; end
      MUL_SU: begin a_sgn = 1'b1; b_sgn = 1'b0; end
      MUL_SS: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default: begin a_sgn = 1'b0; b_sgn = 1'b0; end
    endcase
  end

  // Accumulate the current digit at weight 4^cnt.
  always_comb begin
    shamt          = {cnt_q, 1'b0};
    pp_ext         = ACCW'($signed(pp_c));
    step_sum       = acc_q + (pp_ext << shamt) + (ACCW'(neg_c) << shamt);
    unused_acc_top = ^step_sum[ACCW-1:2*XLEN];
    last_step      = (cnt_q == (mulw_q ? CNTW'(W32_STEPS - 1) : CNTW'(STEPS - 1)));
    accept         = mul_valid & ready_q & ~flush;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    a_d         = a_q;
    b_d         = b_q;
    prev_d      = prev_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mulw_d      = mulw_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            state_d = BUSY;
            a_d     = ext_op(multiplicand, a_sgn, mulw);
            b_d     = ext_op(multiplier, b_sgn, mulw);
            prev_d  = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            mulw_d  = mulw;
          end
        end
        BUSY: begin
          acc_d  = step_sum;
          b_d    = {{2{b_q[AW-1]}}, b_q[AW-1:2]};
          prev_d = b_q[1];
          cnt_d  = cnt_q + CNTW'(1);
          if (last_step) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            if (mulw_q) begin
              res_hi_d = XLEN'($signed(step_sum[63:32]));
              res_lo_d = XLEN'($signed(step_sum[31:0]));
            end else begin
              res_hi_d = step_sum[2*XLEN-1:XLEN];
              res_lo_d = step_sum[XLEN-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d != BUSY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prev_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mulw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mulw_q      <= mulw_d;
    end
  end

  assign mul_ready = ready_q;
  assign out_valid = out_valid_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul (XLEN=64): transaction-level product/latency
// model checked every cycle, plus directed vectors with literal expectations.
module tb_booth_seq_mul;

  localparam int unsigned XLEN = 64;

  logic            clock;
  logic            reset;
  logic            mul_valid;
  logic            flush;
  logic            mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            mul_ready;
  logic            out_valid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  booth_seq_mul #(.XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .mul_valid    (mul_valid),
    .flush        (flush),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mul_ready    (mul_ready),
    .out_valid    (out_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference product: extend both operands to full width and multiply modulo 2^width.
  function automatic logic [127:0] ref_prod(input logic w, input logic [1:0] s,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb;
    logic [63:0]  wa, wb, pw;
    if (w) begin
      if (s[1]) wa = 64'($signed(a[31:0])); else wa = 64'(a[31:0]);
      if (s[0]) wb = 64'($signed(b[31:0])); else wb = 64'(b[31:0]);
      pw = wa * wb;
      return {64'($signed(pw[63:32])), 64'($signed(pw[31:0]))};
    end
    if (s[1]) ea = 128'($signed(a)); else ea = 128'(a);
    if (s[0]) eb = 128'($signed(b)); else eb = 128'(b);
    return ea * eb;
  endfunction

  // Transaction model: busy for 33 (or 17) cycles after accept, then one-cycle result.
  logic         m_busy = 1'b0;
  int           m_left = 0;
  logic         m_outv = 1'b0;
  logic [63:0]  m_hi = '0;
  logic [63:0]  m_lo = '0;
  logic [127:0] m_pend = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_left = 0;
      m_outv = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_outv = 1'b0;
      if (flush) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_outv = 1'b1;
          m_hi   = m_pend[127:64];
          m_lo   = m_pend[63:0];
        end
      end else if (mul_valid) begin
        m_pend = ref_prod(mulw, mul_signed, multiplicand, multiplier);
        m_busy = 1'b1;
        m_left = mulw ? 17 : 33;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_out_valid", 128'(out_valid), 128'(m_outv));
      chk("cyc_mul_ready", 128'(mul_ready), 128'(!m_busy));
      chk("cyc_result_hi", 128'(result_hi), 128'(m_hi));
      chk("cyc_result_lo", 128'(result_lo), 128'(m_lo));
    end
  end

  // Issue one request; returns at the negedge after the accept edge.
  task automatic start_op(input logic w, input logic [1:0] s, input logic [63:0] a,
                          input logic [63:0] b, input string nm);
    int n;
    n = 0;
    while (!mul_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("%s_ready", nm), 128'(mul_ready), 128'(1));
    mulw         = w;
    mul_signed   = s;
    multiplicand = a;
    multiplier   = b;
    mul_valid    = 1'b1;
    @(negedge clock);
    mul_valid    = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    mul_signed   = 2'($urandom_range(0, 3));
    mulw         = ~w;
  endtask

  // Wait for completion; lat0 = cycles since accept already spent by the caller.
  task automatic wait_done(input logic w, input int lat0, input logic lit,
                           input logic [63:0] ehi, input logic [63:0] elo, input string nm);
    int lat;
    lat = lat0;
    while (!out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk($sformatf("%s_latency", nm), 128'(lat), w ? 128'(17) : 128'(33));
    if (lit) begin
      chk($sformatf("%s_hi", nm), 128'(result_hi), 128'(ehi));
      chk($sformatf("%s_lo", nm), 128'(result_lo), 128'(elo));
    end
  endtask

  task automatic do_op(input logic w, input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] b, input logic lit, input logic [63:0] ehi,
                       input logic [63:0] elo, input string nm);
    start_op(w, s, a, b, nm);
    wait_done(w, 0, lit, ehi, elo, nm);
  endtask

  task automatic pulse_check(input string nm);
    @(negedge clock);
    chk($sformatf("%s_pulse", nm), 128'(out_valid), 128'(0));
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int n;
    reset        = 1'b1;
    mul_valid    = 1'b0;
    flush        = 1'b0;
    mulw         = 1'b0;
    mul_signed   = 2'b00;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clock);
    chk("reset_ready", 128'(mul_ready), 128'(1));
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_hi", 128'(result_hi), 128'(0));
    chk("reset_lo", 128'(result_lo), 128'(0));
    reset  = 1'b0;
    cmp_en = 1'b1;

    do_op(1'b0, 2'b11, ALL1, ALL1, 1'b1, 64'h0, 64'h1, "ss_m1_m1");
    pulse_check("ss_m1_m1");
    do_op(1'b0, 2'b00, ALL1, ALL1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, "uu_max");
    pulse_check("uu_max");
    do_op(1'b0, 2'b10, ALL1, 64'h8000_0000_0000_0000, 1'b1, ALL1,
          64'h8000_0000_0000_0000, "su_min");
    pulse_check("su_min");
    do_op(1'b1, 2'b11, 64'h0000_0000_7FFF_FFFF, 64'h2, 1'b1, 64'h0,
          64'hFFFF_FFFF_FFFF_FFFE, "mulw_ss");
    pulse_check("mulw_ss");
    do_op(1'b0, 2'b01, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, ALL1,
          64'hFFFF_FFFF_FFFF_FFFA, "us_3_m2");
    do_op(1'b1, 2'b00, 64'h1234_5678_FFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 64'h1, "mulw_uu");
    pulse_check("mulw_uu");

    // Requests during BUSY must be ignored.
    start_op(1'b0, 2'b11, 64'h3, 64'hFFFF_FFFF_FFFF_FFFB, "busy_ign");
    for (int i = 0; i < 10; i++) begin
      mul_valid    = 1'b1;
      multiplicand = {$urandom, $urandom};
      multiplier   = {$urandom, $urandom};
      @(negedge clock);
    end
    mul_valid = 1'b0;
    wait_done(1'b0, 10, 1'b1, ALL1, 64'hFFFF_FFFF_FFFF_FFF1, "busy_ign");
    pulse_check("busy_ign");

    // Back-to-back: second request accepted in the DONE cycle.
    do_op(1'b0, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 64'h1, 64'h0, "b2b_a");
    do_op(1'b1, 2'b11, 64'hFFFF_FFFD, 64'h7, 1'b1, ALL1, 64'hFFFF_FFFF_FFFF_FFEB, "b2b_b");
    pulse_check("b2b_b");

    // Flush five cycles into an op, with a simultaneous request that must be dropped.
    start_op(1'b0, 2'b11, ALL1, ALL1, "flush5");
    repeat (4) @(negedge clock);
    flush        = 1'b1;
    mul_valid    = 1'b1;
    multiplicand = 64'h55;
    multiplier   = 64'h66;
    @(negedge clock);
    flush     = 1'b0;
    mul_valid = 1'b0;
    chk("flush5_ready", 128'(mul_ready), 128'(1));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) n++;
    end
    chk("flush5_no_valid", 128'(n), 128'(0));
    do_op(1'b0, 2'b11, 64'h1234, 64'h10, 1'b1, 64'h0, 64'h12340, "post_flush");
    pulse_check("post_flush");

    // Flush on the final step: completion suppressed, results held.
    start_op(1'b0, 2'b11, 64'h5, 64'h5, "flush_last");
    repeat (32) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_last_valid", 128'(out_valid), 128'(0));
    chk("flush_last_ready", 128'(mul_ready), 128'(1));
    chk("flush_last_hi", 128'(result_hi), 128'(0));
    chk("flush_last_lo", 128'(result_lo), 128'(64'h12340));
    repeat (3) @(negedge clock);

    // Reset in the middle of BUSY.
    start_op(1'b0, 2'b00, ALL1, 64'h3, "rst_mid");
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ready", 128'(mul_ready), 128'(1));
    chk("rst_mid_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_hi", 128'(result_hi), 128'(0));
    chk("rst_mid_lo", 128'(result_lo), 128'(0));
    reset = 1'b0;
    do_op(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1,
          64'h0, 64'h3F, "post_rst");

    // Mixed operands checked by the model only.
    for (int i = 0; i < 8; i++) begin
      do_op(1'(i >= 4), 2'(i % 4), {$urandom, $urandom}, {$urandom, $urandom},
            1'b0, 64'h0, 64'h0, "mixed");
    end

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
